// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC AXI-stream packetizer.
// Holds the framing state enum, header/trailer field layout, and a beat packer.
package adc_pkt_pkg;

    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned KEEP_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned LEN_WIDTH   = 16;
    localparam int unsigned SEQ_WIDTH   = 16;
    localparam int unsigned CNT_WIDTH   = 32;
    localparam int unsigned FLAGS_WIDTH = 8;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hADC0;

    localparam logic [7:0] PKT_TYPE_HDR = 8'h00;
    localparam logic [7:0] PKT_TYPE_TRL = 8'h01;

    localparam int unsigned FLAG_EARLY      = 0;
    localparam int unsigned FLAG_EXACT_LAST = 1;

    // Bit offsets of the header/trailer fields inside a 64-bit beat
    localparam int unsigned OFS_MAGIC = 48;
    localparam int unsigned OFS_SEQ   = 32;
    localparam int unsigned OFS_LEN   = 16;
    localparam int unsigned OFS_FLAGS = 8;
    localparam int unsigned OFS_TYPE  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAILER = 2'd3
    } pkt_state_e;

    // Assemble a header or trailer beat; fld is length (header) or beat count (trailer)
    function automatic logic [DATA_WIDTH-1:0] pack_beat(
        input logic [15:0]            magic,
        input logic [SEQ_WIDTH-1:0]   seq,
        input logic [LEN_WIDTH-1:0]   fld,
        input logic [FLAGS_WIDTH-1:0] flags,
        input logic [7:0]             ptype
    );
        logic [DATA_WIDTH-1:0] beat;
        beat                            = '0;
        beat[OFS_MAGIC +: 16]           = magic;
        beat[OFS_SEQ   +: SEQ_WIDTH]    = seq;
        beat[OFS_LEN   +: LEN_WIDTH]    = fld;
        beat[OFS_FLAGS +: FLAGS_WIDTH]  = flags;
        beat[OFS_TYPE  +: 8]            = ptype;
        return beat;
    endfunction

endpackage

// File: rtl/adc_axis_packetizer_if.sv
// AXI-stream bundle used on both sides of the packetizer.
// master: drives tdata/tvalid/tlast/tuser/tkeep, receives tready.
// slave:  receives tdata/tvalid/tlast/tuser/tkeep, drives tready.
interface adc_axis_packetizer_if;
    import adc_pkt_pkg::*;

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;
    logic [KEEP_WIDTH-1:0] tkeep;

    modport master (output tdata, tvalid, tlast, tuser, tkeep, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, tkeep, output tready);

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI-stream register slice feeding the m_axis port.
// Ports: aclk/aresetn; load_* offers a beat, load_ready_c says it is taken
// this cycle (slot empty or being drained); m_axis is the registered output.
module axis_out_reg
    import adc_pkt_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  load_user,
    output logic                  load_ready_c,
    adc_axis_packetizer_if.master m_axis
);

    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  tuser_q;

    // Slot frees when empty or when the current beat is accepted this cycle
    assign load_ready_c = !tvalid_q || m_axis.tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else if (load_valid && load_ready_c) begin
            tdata_q  <= load_data;
            tvalid_q <= 1'b1;
            tlast_q  <= load_last;
            tuser_q  <= load_user;
        end else if (m_axis.tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tkeep  = {KEEP_WIDTH{1'b1}};

endmodule

// File: rtl/adc_axis_packetizer.sv
// Frames the ADC sample stream into header / payload / trailer packets.
// Ports: aclk, aresetn (async, active-low); enable gates new packets;
// cfg_payload_beats is the payload length (0 means 1), latched at packet start;
// s_axis is the ADC sample input, m_axis the framed output; pkt_count counts
// accepted trailers.
module adc_axis_packetizer
    import adc_pkt_pkg::*;
#(
    parameter logic [15:0] HEADER_MAGIC = HDR_MAGIC_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  cfg_payload_beats,
    adc_axis_packetizer_if.slave  s_axis,
    adc_axis_packetizer_if.master m_axis,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    pkt_state_e             state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [SEQ_WIDTH-1:0]   seq;
    logic [FLAGS_WIDTH-1:0] flags_q;
    logic                   trl_loaded;

    logic                   out_free_c;
    logic                   load_valid;
    logic [DATA_WIDTH-1:0]  load_data;
    logic                   load_last;
    logic                   load_user;
    logic [LEN_WIDTH-1:0]   len_start_c;
    logic [LEN_WIDTH-1:0]   cnt_next_c;
    logic                   s_fire_c;
    logic                   m_fire_c;
    logic                   unused_s_sideband;

    // Upstream sideband carries nothing for this block
    assign unused_s_sideband = ^{s_axis.tuser, s_axis.tkeep};

    assign len_start_c = (cfg_payload_beats == '0) ? LEN_WIDTH'(1) : cfg_payload_beats;
    assign cnt_next_c  = beat_cnt + LEN_WIDTH'(1);

    // Upstream is only ever pulled while framing payload
    assign s_axis.tready = (state == ST_PAYLOAD) && out_free_c;
    assign s_fire_c      = s_axis.tvalid && s_axis.tready;
    assign m_fire_c      = m_axis.tvalid && m_axis.tready;

    // Selects what is offered to the output register in each state
    always_comb begin
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        load_user  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                load_valid = enable && s_axis.tvalid;
                load_data  = pack_beat(HEADER_MAGIC, seq, len_start_c, '0, PKT_TYPE_HDR);
                load_user  = 1'b1;
            end
            ST_PAYLOAD: begin
                load_valid = s_axis.tvalid;
                load_data  = s_axis.tdata;
            end
            ST_TRAILER: begin
                load_valid = !trl_loaded;
                load_data  = pack_beat(HEADER_MAGIC, seq, beat_cnt, flags_q, PKT_TYPE_TRL);
                load_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Framing FSM and counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            len_q      <= LEN_WIDTH'(1);
            beat_cnt   <= '0;
            seq        <= '0;
            flags_q    <= '0;
            trl_loaded <= 1'b0;
            pkt_count  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (enable && s_axis.tvalid && out_free_c) begin
                        len_q <= len_start_c;
                        state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (m_fire_c) begin
                        beat_cnt <= '0;
                        state    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (s_fire_c) begin
                        beat_cnt <= cnt_next_c;
                        if (s_axis.tlast || (cnt_next_c == len_q)) begin
                            flags_q                  <= '0;
                            flags_q[FLAG_EARLY]      <= s_axis.tlast && (cnt_next_c != len_q);
                            flags_q[FLAG_EXACT_LAST] <= s_axis.tlast && (cnt_next_c == len_q);
                            trl_loaded               <= 1'b0;
                            state                    <= ST_TRAILER;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (!trl_loaded) begin
                        if (out_free_c) begin
                            trl_loaded <= 1'b1;
                        end
                    end else if (m_fire_c) begin
                        seq       <= seq + SEQ_WIDTH'(1);
                        pkt_count <= pkt_count + CNT_WIDTH'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_out_reg u_out_reg (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_user    (load_user),
        .load_ready_c (out_free_c),
        .m_axis       (m_axis)
    );

endmodule

// File: tb/tb_adc_axis_packetizer.sv
// Self-checking bench for adc_axis_packetizer: a packet-level model turns the
// upstream beat list into the expected output beat sequence.
module tb_adc_axis_packetizer;
    import adc_pkt_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [15:0] cfg_payload_beats;
    logic [31:0] pkt_count;

    adc_axis_packetizer_if s_if ();
    adc_axis_packetizer_if m_if ();

    adc_axis_packetizer dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .enable            (enable),
        .cfg_payload_beats (cfg_payload_beats),
        .s_axis            (s_if),
        .m_axis            (m_if),
        .pkt_count         (pkt_count)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [64:0] drv_q[$];   // {last, data} still to be offered to the DUT
    logic [64:0] mdl_q[$];   // same beats, consumed by the model
    logic [65:0] exp_q[$];   // {tlast, tuser, tdata} expected on m_axis
    logic [15:0] mseq   = '0;
    logic [31:0] mpkts  = '0;
    bit          rand_ready = 1'b0;

    int          hdr_seen = 0;
    int          pay_seen = 0;
    logic [63:0] first_hdr = '0;
    logic [63:0] last_hdr  = '0;
    logic [63:0] prev_hdr  = '0;
    logic [63:0] last_trl  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Packet-level model: chunk upstream beats by length / tlast
    task automatic model_pkts(input int cfg, input int npkts);
        int          len;
        int          cnt;
        logic [7:0]  flags;
        logic [64:0] b;
        bit          done;
        for (int p = 0; p < npkts; p++) begin
            len = (cfg == 0) ? 1 : cfg;
            exp_q.push_back({1'b0, 1'b1, 16'hADC0, mseq, 16'(len), 8'h00, 8'h00});
            cnt = 0; flags = 8'h00; done = 1'b0;
            while (!done && mdl_q.size() != 0) begin
                b = mdl_q.pop_front();
                cnt++;
                exp_q.push_back({2'b00, b[63:0]});
                if (b[64]) begin
                    flags = (cnt < len) ? 8'h01 : 8'h02;
                    done  = 1'b1;
                end else if (cnt == len) begin
                    done = 1'b1;
                end
            end
            exp_q.push_back({1'b1, 1'b0, 16'hADC0, mseq, 16'(cnt), flags, 8'h01});
            mseq  = mseq + 16'd1;
            mpkts = mpkts + 32'd1;
        end
    endtask

    task automatic push_beats(input int n, input int last_at);
        logic [64:0] b;
        for (int i = 1; i <= n; i++) begin
            b = {(i == last_at), $urandom(), $urandom()};
            drv_q.push_back(b);
            mdl_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge aclk);
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge aclk);
        #2;
    endtask

    // Bus driver and per-cycle compare against the model
    logic        prev_stall = 1'b0;
    logic [65:0] prev_beat  = '0;
    initial begin
        logic [65:0] cur;
        logic [65:0] e;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tkeep  = '0;
        m_if.tready = 1'b1;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                s_if.tvalid = 1'b0;
                m_if.tready = 1'b1;
                prev_stall  = 1'b0;
                continue;
            end
            m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drv_q.size() != 0) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = drv_q[0][63:0];
                s_if.tlast  = drv_q[0][64];
            end else begin
                s_if.tvalid = 1'b0;
                s_if.tdata  = '0;
                s_if.tlast  = 1'b0;
            end
            #1;
            cur = {m_if.tlast, m_if.tuser, m_if.tdata};
            if (prev_stall) begin
                check("stall_valid", 64'(m_if.tvalid), 64'd1);
                check("stall_data", m_if.tdata, prev_beat[63:0]);
                check("stall_flags", 64'(cur[65:64]), 64'(prev_beat[65:64]));
            end
            if (s_if.tready)
                check("s_ready_when_full", 64'(!m_if.tvalid || m_if.tready), 64'd1);
            if (m_if.tvalid && m_if.tready) begin
                check("tkeep", 64'(m_if.tkeep), 64'hFF);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_if.tdata, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_if.tdata, e[63:0]);
                    check("beat_last_user", 64'(cur[65:64]), 64'(e[65:64]));
                end
                if (m_if.tuser) begin
                    if (hdr_seen == 0) first_hdr = m_if.tdata;
                    prev_hdr = last_hdr;
                    last_hdr = m_if.tdata;
                    hdr_seen++;
                end else if (m_if.tlast) begin
                    last_trl = m_if.tdata;
                end else begin
                    pay_seen++;
                end
            end
            if (s_if.tvalid && s_if.tready) void'(drv_q.pop_front());
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = cur;
        end
    end

    initial begin
        int base;
        aresetn           = 1'b0;
        enable            = 1'b0;
        cfg_payload_beats = 16'd4;
        repeat (3) @(negedge aclk);
        #2;
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_tuser", 64'(m_if.tuser), 64'd0);
        check("rst_tdata", m_if.tdata, 64'd0);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_tkeep", 64'(m_if.tkeep), 64'hFF);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        #2;

        // len=4, 10 beats, enable dropped during the second packet
        cfg_payload_beats = 16'd4;
        enable = 1'b1;
        base = hdr_seen;
        push_beats(10, 0);
        model_pkts(4, 2);
        for (int i = 0; i < 200 && hdr_seen < base + 2; i++) @(negedge aclk);
        #2;
        enable = 1'b0;
        cfg_payload_beats = 16'd9;   // must not affect the packet in flight
        wait_drain("t1_drain", 200);
        check("t1_first_hdr", first_hdr, 64'hADC0_0000_0004_0000);
        check("t1_left_upstream", 64'(drv_q.size()), 64'd2);
        check("t1_s_tready_idle", 64'(s_if.tready), 64'd0);
        check("t1_pkt_count", 64'(pkt_count), 64'(mpkts));
        check("t1_pkt_count_lit", 64'(pkt_count), 64'd2);
        drv_q.delete();
        mdl_q.delete();
        repeat (2) @(negedge aclk);
        #2;

        // len=8, tlast on beat 3: early close
        cfg_payload_beats = 16'd8;
        enable = 1'b1;
        push_beats(3, 3);
        model_pkts(8, 1);
        wait_drain("t2_drain", 200);
        check("t2_trailer", last_trl, 64'hADC0_0002_0003_0101);

        // len=5, tlast on beat 5: exact close
        cfg_payload_beats = 16'd5;
        push_beats(5, 5);
        model_pkts(5, 1);
        wait_drain("t3_drain", 200);
        check("t3_trailer", last_trl, 64'hADC0_0003_0005_0201);

        // len=16, random downstream backpressure
        cfg_payload_beats = 16'd16;
        rand_ready = 1'b1;
        push_beats(32, 0);
        model_pkts(16, 2);
        wait_drain("t4_drain", 600);
        rand_ready = 1'b0;
        check("t4_pkt_count", 64'(pkt_count), 64'(mpkts));

        // cfg=0 behaves as one payload beat per packet
        cfg_payload_beats = 16'd0;
        push_beats(3, 0);
        model_pkts(0, 3);
        wait_drain("t5_drain", 200);
        check("t5_last_hdr", last_hdr, 64'hADC0_0008_0001_0000);

        // sequence wrap from 16'hFFFF
        enable = 1'b0;
        @(negedge aclk);
        #2;
        force dut.seq = 16'hFFFF;
        @(negedge aclk);
        #2;
        release dut.seq;
        mseq = 16'hFFFF;
        cfg_payload_beats = 16'd2;
        enable = 1'b1;
        push_beats(4, 0);
        model_pkts(2, 2);
        wait_drain("t6_drain", 200);
        check("t6_hdr_ffff", prev_hdr, 64'hADC0_FFFF_0002_0000);
        check("t6_hdr_0000", last_hdr, 64'hADC0_0000_0002_0000);
        check("t6_pkt_count", 64'(pkt_count), 64'd11);

        // reset in the middle of a payload
        cfg_payload_beats = 16'd8;
        base = pay_seen;
        push_beats(8, 0);
        model_pkts(8, 1);
        for (int i = 0; i < 200 && pay_seen < base + 2; i++) @(negedge aclk);
        check("t7_reached_payload", 64'(pay_seen >= base + 2), 64'd1);
        @(negedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check("t7_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("t7_rst_tdata", m_if.tdata, 64'd0);
        check("t7_rst_tlast_tuser", 64'({m_if.tlast, m_if.tuser}), 64'd0);
        check("t7_rst_s_tready", 64'(s_if.tready), 64'd0);
        check("t7_rst_pkt_count", 64'(pkt_count), 64'd0);
        drv_q.delete();
        mdl_q.delete();
        exp_q.delete();
        mseq  = '0;
        mpkts = '0;
        repeat (2) @(negedge aclk);
        #3;
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        #2;
        push_beats(8, 0);
        model_pkts(8, 1);
        wait_drain("t7_drain", 200);
        check("t7_hdr_after_rst", last_hdr, 64'hADC0_0000_0008_0000);
        check("t7_pkt_count", 64'(pkt_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
